// File: rtl/chunked_add_sequencer_pkg.sv
// Shared types and helpers for the chunked add/subtract sequencer.
package add_seq_pkg;

  // Sequencer control states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } seq_state_e;

  localparam int CHUNK_DEF   = 4;
  localparam int NCHUNKS_DEF = 4;

  // Width of the chunk index counter; never narrower than one bit.
  function automatic int idx_width(input int nchunks);
    if (nchunks <= 2) begin
      return 1;
    end else begin
      return $clog2(nchunks);
    end
  endfunction

  // Operand B as presented to the adder: inverted for subtraction.
  function automatic logic [CHUNK_DEF*NCHUNKS_DEF-1:0] cond_invert(
      input logic [CHUNK_DEF*NCHUNKS_DEF-1:0] val,
      input logic                             inv);
    return val ^ {(CHUNK_DEF*NCHUNKS_DEF){inv}};
  endfunction

endpackage

// File: rtl/chunked_add_sequencer_if.sv
// Operand/result handshake bundle for the chunked add/subtract sequencer.
interface chunked_add_sequencer_if #(
  parameter int OP_WIDTH = 16
);
  logic                in_valid;
  logic                in_ready;
  logic [OP_WIDTH-1:0] a;
  logic [OP_WIDTH-1:0] b;
  logic                cin;
  logic                sub;
  logic                out_valid;
  logic                out_ready;
  logic [OP_WIDTH-1:0] sum;
  logic                cout;
  logic                ovf;

  // Producer/consumer side (drives operands, accepts results).
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  // Sequencer side.
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/chunked_add_sequencer_rca_chunk.sv
// CHUNK-bit ripple-carry adder built from full-adder cells. Exposes the carry
// into the MSB cell so the caller can derive signed overflow.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module rca_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             cout_o,
  output logic             msb_cin_o
);
  logic [CHUNK:0] carry_s;

  assign carry_s[0] = cin_i;

  for (genvar i = 0; i < CHUNK; i++) begin : g_cell
    full_adder u_fa (
      .a_i (a_i[i]),
      .b_i (b_i[i]),
      .c_i (carry_s[i]),
      .s_o (sum_o[i]),
      .c_o (carry_s[i+1])
    );
  end

  assign cout_o    = carry_s[CHUNK];
  assign msb_cin_o = carry_s[CHUNK-1];
endmodule

// File: rtl/chunked_add_sequencer.sv
// Multi-cycle wide adder/subtractor: one CHUNK-bit adder is reused NCHUNKS
// times, LSB chunk first, with the carry held in a register between cycles.
module chunked_add_sequencer
  import add_seq_pkg::*;
#(
  parameter int CHUNK   = CHUNK_DEF,
  parameter int NCHUNKS = NCHUNKS_DEF
) (
  input logic                    clk,
  input logic                    rst,
  chunked_add_sequencer_if.slave bus
);
  localparam int                OP_WIDTH = CHUNK * NCHUNKS;
  localparam int                IDX_W    = idx_width(NCHUNKS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NCHUNKS - 1);

  seq_state_e          state_q, state_d;
  logic [OP_WIDTH-1:0] a_q, a_d;
  logic [OP_WIDTH-1:0] b_q, b_d;
  logic                carry_q, carry_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [OP_WIDTH-1:0] sum_q, sum_d;
  logic                cout_q, cout_d;
  logic                ovf_q, ovf_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;

  logic [CHUNK-1:0]    a_chunk_s;
  logic [CHUNK-1:0]    b_chunk_s;
  logic [CHUNK-1:0]    chunk_sum_s;
  logic                chunk_cout_s;
  logic                chunk_msb_cin_s;

  // Select the chunk currently being summed from the latched operands.
  assign a_chunk_s = a_q[int'(idx_q)*CHUNK +: CHUNK];
  assign b_chunk_s = b_q[int'(idx_q)*CHUNK +: CHUNK];

  rca_chunk #(.CHUNK(CHUNK)) u_rca (
    .a_i       (a_chunk_s),
    .b_i       (b_chunk_s),
    .cin_i     (carry_q),
    .sum_o     (chunk_sum_s),
    .cout_o    (chunk_cout_s),
    .msb_cin_o (chunk_msb_cin_s)
  );

  // Next-state and datapath updates for the IDLE -> ADD -> DONE sequence.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          // Subtraction is a + ~b + 1, so invert B and force the carry-in.
          a_d        = bus.a;
          b_d        = bus.b ^ {OP_WIDTH{bus.sub}};
          carry_d    = bus.sub ? 1'b1 : bus.cin;
          idx_d      = '0;
          in_ready_d = 1'b0;
          state_d    = S_ADD;
        end else begin
          in_ready_d = 1'b1;
        end
      end
      S_ADD: begin
        sum_d[int'(idx_q)*CHUNK +: CHUNK] = chunk_sum_s;
        carry_d = chunk_cout_s;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          cout_d      = chunk_cout_s;
          ovf_d       = chunk_cout_s ^ chunk_msb_cin_s;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          out_valid_d = 1'b0;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State, operand, carry and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_chunked_add_sequencer.sv
// Directed bench for the chunked add/subtract sequencer (CHUNK=4, NCHUNKS=4).
module tb_chunked_add_sequencer;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  chunked_add_sequencer_if #(.OP_WIDTH(16)) bus ();

  chunked_add_sequencer #(.CHUNK(4), .NCHUNKS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete operation: accept, latency, result, optional stall, handshake.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub, input logic [15:0] exp_sum,
                        input logic exp_cout, input logic exp_ovf, input int stall);
    check({tag, "_pre_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    bus.sub      = sub;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.a        = 16'h0000;
    bus.b        = 16'h0000;
    for (int k = 1; k <= 3; k++) begin
      check({tag, "_busy_in_ready"}, 32'(bus.in_ready), 32'd0);
      check({tag, "_early_out_valid"}, 32'(bus.out_valid), 32'd0);
      tick();
    end
    tick();
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_done_in_ready"}, 32'(bus.in_ready), 32'd0);
    check({tag, "_sum"}, 32'(bus.sum), 32'(exp_sum));
    check({tag, "_cout"}, 32'(bus.cout), 32'(exp_cout));
    check({tag, "_ovf"}, 32'(bus.ovf), 32'(exp_ovf));
    if (stall > 0) begin
      bus.out_ready = 1'b0;
      for (int k = 0; k < stall; k++) begin
        tick();
        check({tag, "_stall_out_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_stall_sum"}, 32'(bus.sum), 32'(exp_sum));
        check({tag, "_stall_in_ready"}, 32'(bus.in_ready), 32'd0);
      end
      bus.out_ready = 1'b1;
    end
    tick();
    check({tag, "_post_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_post_in_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_hold_sum"}, 32'(bus.sum), 32'(exp_sum));
  endtask

  initial begin
    logic [15:0] ra, rb, bv, rsum;
    logic        rcin, rsub, cin_eff, rovf;
    logic [16:0] full;
    int          rstall;

    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = 16'h0000;
    bus.b         = 16'h0000;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_sum", 32'(bus.sum), 32'd0);
    check("rst_cout", 32'(bus.cout), 32'd0);
    check("rst_ovf", 32'(bus.ovf), 32'd0);
    rst = 1'b0;
    tick();

    run_op("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 0);
    run_op("add_ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
    run_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
    run_op("sub_neg", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 0);
    run_op("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 0);
    run_op("stall", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 10);
    run_op("b2b", 16'h00FF, 16'h0001, 1'b1, 1'b0, 16'h0101, 1'b0, 1'b0, 0);

    // Reset in the second ADD cycle discards the operation.
    bus.a        = 16'h1111;
    bus.b        = 16'h2222;
    bus.cin      = 1'b0;
    bus.sub      = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    check("midrst_sum", 32'(bus.sum), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("postrst_out_valid", 32'(bus.out_valid), 32'd0);
    run_op("postrst_add", 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 0);

    // Pseudo-random operations against an arithmetic reference model.
    for (int n = 0; n < 40; n++) begin
      ra      = 16'($urandom);
      rb      = 16'($urandom);
      rcin    = 1'($urandom);
      rsub    = 1'($urandom);
      rstall  = int'($urandom_range(0, 3));
      bv      = rsub ? ~rb : rb;
      cin_eff = rsub ? 1'b1 : rcin;
      full    = {1'b0, ra} + {1'b0, bv} + {16'h0000, cin_eff};
      rsum    = full[15:0];
      rovf    = (ra[15] == bv[15]) && (rsum[15] != ra[15]);
      run_op("rand", ra, rb, rcin, rsub, rsum, full[16], rovf, rstall);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
